// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor that handles one CHUNK-bit slice of the operands per clock.
// The operands shift right as chunks are consumed, and the result shifts in from the top.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CHUNK:0]   chunkSum;
    logic             lastChunk;

    // The lowest CHUNK bits of the shifting operands are always the chunk being processed.
    assign chunkSum  = {1'b0, opA_q[CHUNK-1:0]} + {1'b0, opB_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    assign lastChunk = (idx_q == IW'(N - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d   = a;
                    opB_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = (s_q >> CHUNK) | (WIDTH'(chunkSum[CHUNK-1:0]) << (WIDTH - CHUNK));
                opA_d   = opA_q >> CHUNK;
                opB_d   = opB_q >> CHUNK;
                carry_d = chunkSum[CHUNK];
                idx_d   = idx_q + IW'(1);
                if (lastChunk) begin
                    // On the last chunk the slice MSBs are the operand MSBs, so ovf is formed here.
                    idx_d   = '0;
                    cout_d  = chunkSum[CHUNK];
                    ovf_d   = (opA_q[CHUNK-1] == opB_q[CHUNK-1]) &&
                              (chunkSum[CHUNK-1] != opA_q[CHUNK-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed and random checks of chunked_addsub for four (WIDTH, CHUNK) configurations,
// using a per-instance queue of expected results built from integer arithmetic.
module tb_chunked_addsub;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic        rStart [4];
    logic        rSub   [4];
    logic        rCin   [4];
    logic [15:0] rA     [4];
    logic [15:0] rB     [4];
    wire  [3:0]        rBusy, rDone, rCout, rOvf;
    wire  [3:0][15:0]  rS;
    wire  [7:0]        s8;

    int compareCount = 0;
    int failCount    = 0;
    exp_t expQ [4][$];

    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .start(rStart[0]), .sub(rSub[0]), .a(rA[0]), .b(rB[0]),
        .cin(rCin[0]), .busy(rBusy[0]), .done(rDone[0]), .s(rS[0]), .cout(rCout[0]), .ovf(rOvf[0]));
    chunked_addsub #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(rStart[1]), .sub(rSub[1]), .a(rA[1]), .b(rB[1]),
        .cin(rCin[1]), .busy(rBusy[1]), .done(rDone[1]), .s(rS[1]), .cout(rCout[1]), .ovf(rOvf[1]));
    chunked_addsub #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .rst(rst), .start(rStart[2]), .sub(rSub[2]), .a(rA[2]), .b(rB[2]),
        .cin(rCin[2]), .busy(rBusy[2]), .done(rDone[2]), .s(rS[2]), .cout(rCout[2]), .ovf(rOvf[2]));
    chunked_addsub #(.WIDTH(8), .CHUNK(2)) dut3 (
        .clk(clk), .rst(rst), .start(rStart[3]), .sub(rSub[3]), .a(rA[3][7:0]), .b(rB[3][7:0]),
        .cin(rCin[3]), .busy(rBusy[3]), .done(rDone[3]), .s(s8), .cout(rCout[3]), .ovf(rOvf[3]));
    assign rS[3] = {8'h00, s8};

    // Golden result from unsigned and signed integer arithmetic at width w.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin);
        exp_t   m;
        longint lim  = longint'(1) << w;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = a[w-1] ? ua - lim : ua;
        longint sb   = b[w-1] ? ub - lim : ub;
        longint ures;
        longint sres;
        if (sub) begin
            ures   = ua - ub;
            sres   = sa - sb;
            m.cout = (ua >= ub);
        end else begin
            ures   = ua + ub + longint'(cin);
            sres   = sa + sb + longint'(cin);
            m.cout = (ures >= lim);
        end
        m.s   = 16'(ures & (lim - 1));
        m.ovf = (sres >= lim / 2) || (sres < -(lim / 2));
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compareCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drives operands with start high at a falling edge and queues the expected result.
    task automatic applyStimulus(input int k, input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
        rA[k]     = a;
        rB[k]     = b;
        rSub[k]   = sub;
        rCin[k]   = cin;
        rStart[k] = 1'b1;
        expQ[k].push_back(model(w, a, b, sub, cin));
    endtask

    task automatic waitDone(input int k, input int limit, output int cycles, output int busyCycles,
                            output bit seen);
        cycles     = 0;
        busyCycles = 0;
        seen       = 1'b0;
        while (cycles < limit && !seen) begin
            @(negedge clk);
            cycles++;
            if (rDone[k]) seen = 1'b1;
            else if (rBusy[k]) busyCycles++;
        end
    endtask

    task automatic checkResult(input int k, input int w, input string tag);
        exp_t        e;
        logic [15:0] mask = 16'((32'd1 << w) - 1);
        checkOutput({tag, " queue"}, 32'(expQ[k].size() > 0), 32'd1);
        if (expQ[k].size() > 0) begin
            e = expQ[k].pop_front();
            checkOutput({tag, " s"},    32'(rS[k] & mask), 32'(e.s));
            checkOutput({tag, " cout"}, 32'(rCout[k]),     32'(e.cout));
            checkOutput({tag, " ovf"},  32'(rOvf[k]),      32'(e.ovf));
        end
    endtask

    task automatic directedOp(input logic [15:0] a, input logic [15:0] b, input logic sub,
                              input logic cin, input string tag);
        int cyc, bc;
        bit seen;
        applyStimulus(0, 16, a, b, sub, cin);
        waitDone(0, 20, cyc, bc, seen);
        rStart[0] = 1'b0;
        checkOutput({tag, " done seen"}, 32'(seen), 32'd1);
        checkOutput({tag, " latency"},   32'(cyc),  32'd5);
        checkOutput({tag, " busy len"},  32'(bc),   32'd4);
        checkResult(0, 16, tag);
    endtask

    task automatic randomRun(input int k, input int w, input int n, input int nOps);
        int          cyc, bc;
        bit          seen;
        logic [15:0] mask = 16'((32'd1 << w) - 1);
        @(negedge clk);
        for (int op = 0; op < nOps; op++) begin
            applyStimulus(k, w, 16'($urandom) & mask, 16'($urandom) & mask,
                          1'($urandom), 1'($urandom));
            waitDone(k, 2 * n + 10, cyc, bc, seen);
            checkOutput($sformatf("rand%0d done seen", k), 32'(seen), 32'd1);
            if (!seen) break;
            checkOutput($sformatf("rand%0d spacing", k), 32'(cyc), 32'((op == 0) ? n + 1 : n + 2));
            checkOutput($sformatf("rand%0d busy len", k), 32'(bc), 32'(n));
            checkResult(k, w, $sformatf("rand%0d op%0d", k, op));
        end
        rStart[k] = 1'b0;
    endtask

    initial begin
        int doneCount;
        int busyCount;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rStart[i] = 1'b0;
            rSub[i]   = 1'b0;
            rCin[i]   = 1'b0;
            rA[i]     = '0;
            rB[i]     = '0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(rBusy[0]), 32'd0);
        checkOutput("reset done", 32'(rDone[0]), 32'd0);
        checkOutput("reset s",    32'(rS[0]),    32'd0);
        checkOutput("reset cout", 32'(rCout[0]), 32'd0);
        checkOutput("reset ovf",  32'(rOvf[0]),  32'd0);
        rst = 1'b0;

        @(negedge clk);
        directedOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");
        @(negedge clk);
        checkOutput("done one cycle", 32'(rDone[0]), 32'd0);

        directedOp(16'h7FFF, 16'h0001, 1'b0, 1'b0, "posovf");
        repeat (2) @(negedge clk);
        checkOutput("hold s",   32'(rS[0]),   32'h8000);
        checkOutput("hold ovf", 32'(rOvf[0]), 32'd1);

        directedOp(16'h0005, 16'h0007, 1'b1, 1'b1, "sub borrow");
        @(negedge clk);
        directedOp(16'h8000, 16'h0001, 1'b1, 1'b0, "sub ovf");
        @(negedge clk);

        // Operands and start are disturbed while RUN; only the first operation may complete.
        applyStimulus(0, 16, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        rA[0]   = 16'hFFFF;
        rB[0]   = 16'hFFFF;
        rSub[0] = 1'b1;
        begin
            int cyc, bc;
            bit seen;
            waitDone(0, 20, cyc, bc, seen);
            rStart[0] = 1'b0;
            checkOutput("ignore start done seen", 32'(seen), 32'd1);
            checkResult(0, 16, "ignore start");
        end
        doneCount = 0;
        busyCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (rDone[0]) doneCount++;
            if (rBusy[0]) busyCount++;
        end
        checkOutput("no queued done", 32'(doneCount), 32'd0);
        checkOutput("no queued busy", 32'(busyCount), 32'd0);

        // Abort at the second RUN edge; nothing is queued for this operation.
        rA[0] = 16'h0F0F; rB[0] = 16'h1010; rSub[0] = 1'b0; rCin[0] = 1'b0; rStart[0] = 1'b1;
        @(negedge clk);
        rStart[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", 32'(rBusy[0]), 32'd0);
        checkOutput("abort done", 32'(rDone[0]), 32'd0);
        checkOutput("abort s",    32'(rS[0]),    32'd0);
        checkOutput("abort cout", 32'(rCout[0]), 32'd0);
        checkOutput("abort ovf",  32'(rOvf[0]),  32'd0);
        doneCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (rDone[0]) doneCount++;
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);

        rst = 1'b1;
        rStart[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rStart[0] = 1'b0;
        checkOutput("rst over start busy", 32'(rBusy[0]), 32'd0);
        @(negedge clk);
        checkOutput("rst over start idle", 32'(rBusy[0]), 32'd0);

        directedOp(16'h0F0F, 16'h00F1, 1'b0, 1'b1, "after abort");
        @(negedge clk);

        fork
            randomRun(0, 16, 4, 2500);
            randomRun(1, 16, 16, 2500);
            randomRun(2, 16, 1, 2500);
            randomRun(3, 8, 4, 2500);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
